// File: rtl/grid_vga_renderer.sv
// grid_vga_renderer: VGA raster timing plus rendering of a GRID_COLS x GRID_ROWS
// board of square cells (empty/blocked/cat), with a cursor highlight and a
// per-mode background colour.
// Ports:
//   clk, reset (async, active-high)
//   screen_mode        : 0 START, 1 PLAY, 2 LOSE, 3 WIN
//   wr_en/col/row/data : cell store write port (out-of-range writes are dropped)
//   cursor_col/row     : cell that is highlighted when it is empty
//   hCount, vCount     : raster counters
//   hSync, vSync, bright, rgb, frame_start : registered, one cycle behind the counters
module grid_vga_renderer #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit SYNC_POL  = 1'b0,
  parameter int GRID_COLS = 8,
  parameter int GRID_ROWS = 8,
  parameter int CELL_SIZE = 50,
  parameter int CELL_GAP  = 10,
  parameter int GRID_X0   = 85,
  parameter int GRID_Y0   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  screen_mode,
  input  logic        wr_en,
  input  logic [3:0]  wr_col,
  input  logic [3:0]  wr_row,
  input  logic [1:0]  wr_data,
  input  logic [3:0]  cursor_col,
  input  logic [3:0]  cursor_row,
  output logic [9:0]  hCount,
  output logic [9:0]  vCount,
  output logic        hSync,
  output logic        vSync,
  output logic        bright,
  output logic [11:0] rgb,
  output logic        frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // 11-bit constants so that bounds equal to 1024 do not wrap.
  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] HS_END   = 11'(H_SYNC);
  localparam logic [10:0] VS_END   = 11'(V_SYNC);
  localparam logic [10:0] H_VIS0   = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] H_VIS1   = 11'(H_SYNC + H_BACK + H_VISIBLE);
  localparam logic [10:0] V_VIS0   = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] V_VIS1   = 11'(V_SYNC + V_BACK + V_VISIBLE);
  localparam logic [10:0] GRID_H0  = 11'(H_SYNC + H_BACK + GRID_X0);
  localparam logic [10:0] GRID_V0  = 11'(V_SYNC + V_BACK + GRID_Y0);
  localparam logic [9:0]  PITCH_LAST = 10'(CELL_SIZE + CELL_GAP - 1);
  localparam logic [9:0]  CELL_LAST  = 10'(CELL_SIZE - 1);
  localparam logic [3:0]  COL_LAST   = 4'(GRID_COLS - 1);
  localparam logic [3:0]  ROW_LAST   = 4'(GRID_ROWS - 1);

  logic [10:0] h_ext, v_ext;
  logic [9:0]  h_next, v_next;
  logic        line_end;

  assign h_ext = {1'b0, hCount};
  assign v_ext = {1'b0, vCount};

  always_comb begin
    line_end = (h_ext == H_LAST);
    h_next   = line_end ? 10'd0 : hCount + 10'd1;
    v_next   = vCount;
    if (line_end) begin
      v_next = (v_ext == V_LAST) ? 10'd0 : vCount + 10'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hCount <= 10'd0;
      vCount <= 10'd0;
    end else begin
      hCount <= h_next;
      vCount <= v_next;
    end
  end

  // Column/row trackers. They are loaded alongside the counters, so they always
  // describe the current hCount/vCount: cell index plus offset inside the pitch.
  logic       col_act, row_act;
  logic [3:0] col_idx, row_idx;
  logic [9:0] col_off, row_off;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_act <= 1'b0;
      col_idx <= 4'd0;
      col_off <= 10'd0;
    end else if ({1'b0, h_next} == GRID_H0) begin
      col_act <= 1'b1;
      col_idx <= 4'd0;
      col_off <= 10'd0;
    end else if (line_end) begin
      col_act <= 1'b0;
    end else if (col_act) begin
      if (col_off == PITCH_LAST) begin
        col_off <= 10'd0;
        if (col_idx == COL_LAST) col_act <= 1'b0;
        else                     col_idx <= col_idx + 4'd1;
      end else begin
        col_off <= col_off + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_act <= 1'b0;
      row_idx <= 4'd0;
      row_off <= 10'd0;
    end else if (line_end) begin
      if ({1'b0, v_next} == GRID_V0) begin
        row_act <= 1'b1;
        row_idx <= 4'd0;
        row_off <= 10'd0;
      end else if (v_next == 10'd0) begin
        row_act <= 1'b0;
      end else if (row_act) begin
        if (row_off == PITCH_LAST) begin
          row_off <= 10'd0;
          if (row_idx == ROW_LAST) row_act <= 1'b0;
          else                     row_idx <= row_idx + 4'd1;
        end else begin
          row_off <= row_off + 10'd1;
        end
      end
    end
  end

  // Cell store. The rendered pixel reads the pre-write value in the write cycle.
  logic [1:0] cells [GRID_ROWS][GRID_COLS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < GRID_ROWS; r++) begin
        for (int c = 0; c < GRID_COLS; c++) begin
          cells[r][c] <= (r == GRID_ROWS / 2 && c == GRID_COLS / 2) ? 2'd2 : 2'd0;
        end
      end
    end else if (wr_en) begin
      for (int r = 0; r < GRID_ROWS; r++) begin
        for (int c = 0; c < GRID_COLS; c++) begin
          if (wr_row == 4'(r) && wr_col == 4'(c)) cells[r][c] <= wr_data;
        end
      end
    end
  end

  logic [1:0]  cell_val;
  logic        vis, in_cell, at_cursor;
  logic [11:0] pix_rgb;

  always_comb begin
    cell_val = 2'd0;
    for (int r = 0; r < GRID_ROWS; r++) begin
      for (int c = 0; c < GRID_COLS; c++) begin
        if (row_idx == 4'(r) && col_idx == 4'(c)) cell_val = cells[r][c];
      end
    end
  end

  always_comb begin
    vis       = (h_ext >= H_VIS0) && (h_ext < H_VIS1) && (v_ext >= V_VIS0) && (v_ext < V_VIS1);
    in_cell   = col_act && row_act && (col_off <= CELL_LAST) && (row_off <= CELL_LAST);
    // Trackers only run while the index is in range, so an out-of-range cursor never matches.
    at_cursor = (col_idx == cursor_col) && (row_idx == cursor_row);
    pix_rgb   = 12'h000;
    if (!vis) begin
      pix_rgb = 12'h000;
    end else if (in_cell) begin
      if (at_cursor && cell_val == 2'd0) pix_rgb = 12'hAAF;
      else begin
        case (cell_val)
          2'd1:    pix_rgb = 12'h888;
          2'd2:    pix_rgb = 12'hF80;
          default: pix_rgb = 12'hFFF;
        endcase
      end
    end else begin
      case (screen_mode)
        2'd0:    pix_rgb = 12'h00F;
        2'd2:    pix_rgb = 12'hF00;
        2'd3:    pix_rgb = 12'h0F0;
        default: pix_rgb = 12'h000;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hSync       <= ~SYNC_POL;
      vSync       <= ~SYNC_POL;
      bright      <= 1'b0;
      rgb         <= 12'h000;
      frame_start <= 1'b0;
    end else begin
      hSync       <= (h_ext < HS_END) ? SYNC_POL : ~SYNC_POL;
      vSync       <= (v_ext < VS_END) ? SYNC_POL : ~SYNC_POL;
      bright      <= vis;
      rgb         <= pix_rgb;
      frame_start <= (hCount == 10'd0) && (vCount == 10'd0);
    end
  end

endmodule

// File: tb/tb_grid_vga_renderer.sv
// Bench for grid_vga_renderer using a reduced raster so whole frames fit a short run.
// A behavioural model (division/modulo cell mapping) pushes the expected output
// word into a queue each cycle; each scenario pops and compares after the edge.
module tb_grid_vga_renderer;

  localparam int HV = 64, HF = 4, HS = 8, HB = 6;
  localparam int VV = 48, VF = 2, VS = 2, VB = 3;
  localparam int COLS = 8, ROWS = 8, CS = 5, CG = 1, X0 = 5, Y0 = 1;
  localparam int P  = CS + CG;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam bit POL = 1'b0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  screen_mode = 2'd1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_col = 4'd0, wr_row = 4'd0;
  logic [1:0]  wr_data = 2'd0;
  logic [3:0]  cursor_col = 4'd15, cursor_row = 4'd15;
  logic [9:0]  hCount, vCount;
  logic        hSync, vSync, bright, frame_start;
  logic [11:0] rgb;

  typedef struct packed {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        br;
    logic [11:0] rgb;
    logic        fs;
  } exp_t;

  localparam exp_t RST_E = '{h: 10'd0, v: 10'd0, hs: ~POL, vs: ~POL, br: 1'b0, rgb: 12'h000, fs: 1'b0};

  exp_t       sb [$];
  exp_t       e, got;
  logic [1:0] mcells [ROWS][COLS];
  int         mh, mv;
  int         n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  grid_vga_renderer #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_POL(POL), .GRID_COLS(COLS), .GRID_ROWS(ROWS),
    .CELL_SIZE(CS), .CELL_GAP(CG), .GRID_X0(X0), .GRID_Y0(Y0)
  ) dut (
    .clk(clk), .reset(reset), .screen_mode(screen_mode),
    .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row), .wr_data(wr_data),
    .cursor_col(cursor_col), .cursor_row(cursor_row),
    .hCount(hCount), .vCount(vCount), .hSync(hSync), .vSync(vSync),
    .bright(bright), .rgb(rgb), .frame_start(frame_start)
  );

  assign got = {hCount, vCount, hSync, vSync, bright, rgb, frame_start};

  task automatic model_reset();
    mh = 0;
    mv = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        mcells[r][c] = (r == ROWS / 2 && c == COLS / 2) ? 2'd2 : 2'd0;
    sb.delete();
  endtask

  function automatic logic [11:0] model_rgb(int h, int v);
    int gx, gy, c, r;
    if (!(h >= HS + HB && h < HS + HB + HV && v >= VS + VB && v < VS + VB + VV)) return 12'h000;
    gx = h - (HS + HB) - X0;
    gy = v - (VS + VB) - Y0;
    if (gx >= 0 && gy >= 0 && gx / P < COLS && gy / P < ROWS && gx % P < CS && gy % P < CS) begin
      c = gx / P;
      r = gy / P;
      if (mcells[r][c] == 2'd0 && int'(cursor_col) == c && int'(cursor_row) == r) return 12'hAAF;
      case (mcells[r][c])
        2'd1:    return 12'h888;
        2'd2:    return 12'hF80;
        default: return 12'hFFF;
      endcase
    end
    case (screen_mode)
      2'd0:    return 12'h00F;
      2'd2:    return 12'hF00;
      2'd3:    return 12'h0F0;
      default: return 12'h000;
    endcase
  endfunction

  // Predict the outputs for the current raster position, apply any write to the
  // model after the prediction, advance the model, then clock the DUT.
  task automatic tick();
    exp_t x;
    x.hs  = (mh < HS) ? POL : ~POL;
    x.vs  = (mv < VS) ? POL : ~POL;
    x.br  = (mh >= HS + HB && mh < HS + HB + HV && mv >= VS + VB && mv < VS + VB + VV);
    x.rgb = model_rgb(mh, mv);
    x.fs  = (mh == 0 && mv == 0);
    if (wr_en && int'(wr_col) < COLS && int'(wr_row) < ROWS) mcells[wr_row][wr_col] = wr_data;
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
    x.h = 10'(mh);
    x.v = 10'(mv);
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if (got !== RST_E) begin
      n_bad++;
      $display("FAIL reset_async got=%h required=%h", got, RST_E);
    end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (got !== RST_E) begin
      n_bad++;
      $display("FAIL reset_held got=%h required=%h", got, RST_E);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_line();
    int low = 0;
    screen_mode = 2'd1;
    for (int i = 0; i < HT + 1; i++) begin
      tick();
      e = sb.pop_front();
      if (i < HT && hSync == POL) low++;
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL line i=%0d got=%h required=%h", i, got, e);
      end
    end
    n_cmp++;
    if (low !== HS) begin
      n_bad++;
      $display("FAIL hsync_width got=%0d required=%0d", low, HS);
    end
  endtask

  task automatic test_frame();
    int fs_cnt = 0, vs_low = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      e = sb.pop_front();
      if (frame_start) fs_cnt++;
      if (vSync == POL) vs_low++;
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL frame i=%0d got=%h required=%h", i, got, e);
      end
    end
    n_cmp++;
    if (fs_cnt !== 2) begin
      n_bad++;
      $display("FAIL frame_start_count got=%0d required=2", fs_cnt);
    end
    n_cmp++;
    if (vs_low !== 2 * VS * HT) begin
      n_bad++;
      $display("FAIL vsync_width got=%0d required=%0d", vs_low, 2 * VS * HT);
    end
  endtask

  task automatic test_cells();
    int n_hit = 0;
    screen_mode = 2'd1;
    cursor_col  = 4'd15;
    cursor_row  = 4'd15;
    for (int i = 0; i < FRAME; i++) begin
      wr_en = 1'b1;
      if (i == 100)      begin wr_col = 4'd0; wr_row = 4'd0; wr_data = 2'd1; end
      else if (i == 200) begin wr_col = 4'd9; wr_row = 4'd0; wr_data = 2'd1; end
      else if (i == 300) begin wr_col = 4'd0; wr_row = 4'd8; wr_data = 2'd2; end
      else if (i == 400) begin wr_col = 4'd2; wr_row = 4'd3; wr_data = 2'd3; end
      else if (i == 500) begin wr_col = 4'd5; wr_row = 4'd5; wr_data = 2'd2; end
      else if (mh == HS + HB + X0 + P + 2 && mv == VS + VB + Y0 + P + 2) begin
        // Write the cell under the beam: the pixel must still show the old value.
        wr_col = 4'd1; wr_row = 4'd1; wr_data = 2'd1; n_hit++;
      end else wr_en = 1'b0;
      tick();
      e = sb.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL cells i=%0d got=%h required=%h", i, got, e);
      end
    end
    wr_en = 1'b0;
    n_cmp++;
    if (n_hit !== 1) begin
      n_bad++;
      $display("FAIL same_cycle_write_hits got=%0d required=1", n_hit);
    end
  endtask

  task automatic test_modes();
    for (int m = 0; m < 4; m++) begin
      screen_mode = 2'(m);
      cursor_col  = (m % 2 == 0) ? 4'd1 : 4'd4;
      cursor_row  = (m % 2 == 0) ? 4'd0 : 4'd4;
      for (int i = 0; i < FRAME; i++) begin
        tick();
        e = sb.pop_front();
        n_cmp++;
        if (got !== e) begin
          n_bad++;
          $display("FAIL mode%0d i=%0d got=%h required=%h", m, i, got, e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < FRAME; i++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_col  = 4'($urandom_range(0, 15));
      wr_row  = 4'($urandom_range(0, 15));
      wr_data = 2'($urandom_range(0, 3));
      if (i % 64 == 0) begin
        cursor_col = 4'($urandom_range(0, 9));
        cursor_row = 4'($urandom_range(0, 9));
      end
      if (mh == 0) screen_mode = 2'($urandom_range(0, 3));
      tick();
      e = sb.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL b2b i=%0d got=%h required=%h", i, got, e);
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic test_async_reset();
    int guard = 0;
    screen_mode = 2'd1;
    cursor_col  = 4'd15;
    cursor_row  = 4'd15;
    wr_en = 1'b1; wr_col = 4'd0; wr_row = 4'd0; wr_data = 2'd1;
    tick();
    e = sb.pop_front();
    wr_en = 1'b0;
    while (!(mh == 50 && mv == 20) && guard < 2 * FRAME) begin
      tick();
      e = sb.pop_front();
      guard++;
    end
    n_cmp++;
    if (hCount !== 10'd50 || vCount !== 10'd20) begin
      n_bad++;
      $display("FAIL reach_position got=%0d,%0d required=50,20", hCount, vCount);
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (got !== RST_E) begin
      n_bad++;
      $display("FAIL midframe_reset got=%h required=%h", got, RST_E);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    model_reset();
    for (int i = 0; i < FRAME; i++) begin
      tick();
      e = sb.pop_front();
      n_cmp++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL after_reset i=%0d got=%h required=%h", i, got, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_cells();
    test_modes();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/grid_vga_renderer.md
Name: grid_vga_renderer

Overview:
Parametrised VGA timing generator and grid-cell renderer for the cat-trap game. It owns the hCount/vCount raster counters, the sync pulses and the per-cell state store (empty/blocked/cat). It produces registered RGB for a GRID_COLS x GRID_ROWS board of square cells, with a cursor highlight and a per-mode background colour. The game FSM updates cells through a write port and uses frame_start to pace its moves.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FRONT, 16, front porch
H_SYNC, 96, sync pulse width
H_BACK, 48, back porch
V_VISIBLE, 480, active lines
V_FRONT, 10, front porch lines
V_SYNC, 2, sync lines
V_BACK, 33, back porch lines
SYNC_POL, 0, level driven during sync pulse (0 = active-low)
GRID_COLS, 8, cells per row (1..16)
GRID_ROWS, 8, cells per column (1..16)
CELL_SIZE, 50, cell edge in pixels
CELL_GAP, 10, gap between cells in pixels
GRID_X0, 85, grid left offset within visible area
GRID_Y0, 5, grid top offset within visible area

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous, active-high
screen_mode  in  2  0 START, 1 PLAY, 2 LOSE, 3 WIN
wr_en  in  1  cell write strobe
wr_col  in  4  cell column to write
wr_row  in  4  cell row to write
wr_data  in  2  0 empty, 1 blocked, 2 cat, 3 reserved
cursor_col  in  4  highlighted cell column
cursor_row  in  4  highlighted cell row
hCount  out  10  horizontal counter
vCount  out  10  vertical counter
hSync  out  1  horizontal sync
vSync  out  1  vertical sync
bright  out  1  pixel inside visible area
rgb  out  12  pixel colour, {R,G,B} 4 bits each
frame_start  out  1  one-cycle pulse at the start of each frame

Behaviour:
- H_TOTAL = sum of H_*; V_TOTAL = sum of V_*; both must be ≤1024. Defaults give 800 x 525.
- hCount counts 0..H_TOTAL-1 and wraps to 0. vCount increments on each wrap and wraps to 0 after V_TOTAL-1.
- Sync order within a line and within a frame: sync, back porch, visible, front porch.
- Visible region: hCount in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VISIBLE). vCount in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_VISIBLE). Defaults give [144,784) x [35,515).
- Pipeline: hSync, vSync, bright, rgb and frame_start are registered. All describe the counter value of the previous cycle, so they are mutually aligned with latency 1.
- frame_start = 1 for exactly the cycle following hCount=0, vCount=0.
- Sync outputs: hSync = SYNC_POL when hCount < H_SYNC, otherwise ~SYNC_POL. vSync is the same with vCount < V_SYNC.
- Grid coordinates: gx = visible x - GRID_X0, gy = visible y - GRID_Y0, PITCH = CELL_SIZE+CELL_GAP.
- A pixel is in cell (c,r) iff c*PITCH ≤ gx ≤ c*PITCH+CELL_SIZE-1, and likewise for gy/r, with c<GRID_COLS and r<GRID_ROWS.
- Cell lookup uses incremental column/row and in-cell offset counters. No dividers or multipliers in the pixel path.
- Colour priority:
  - not bright -> 000
  - in a cell at the cursor position whose content is empty -> AAF
  - in a cell: empty or reserved -> FFF, blocked -> 888, cat -> F80
  - otherwise background by mode: START 00F, PLAY 000, LOSE F00, WIN 0F0
- Cell store: GRID_COLS*GRID_ROWS x 2-bit flops.
  - A write lands on the clock edge where wr_en=1.
  - A pixel read of the same cell in that cycle shows the old value.
  - Writes with wr_col ≥ GRID_COLS or wr_row ≥ GRID_ROWS are ignored.
  - Writes are accepted in any mode and at any raster position.
- Cursor coordinates out of range: no highlight.
- Reset (asynchronous, mid-frame allowed):
  - hCount=0, vCount=0, bright=0, rgb=000, frame_start=0, hSync=vSync=~SYNC_POL.
  - All cells are empty except cell (GRID_COLS/2, GRID_ROWS/2), which is cat.
  - Counting resumes on the first edge after deassertion.
  - The first frame_start follows that first edge.

Test Plan:
1. Release reset and run 800 cycles -> hCount steps 0..799 then 0. vCount goes 0->1 at the wrap. hSync is low for 96 cycles, lagging hCount by 1.
2. Run 420000 cycles -> vCount wraps 524->0. frame_start pulses exactly once per 420000 cycles. vSync is low for 2 lines.
3. After reset, mode PLAY, pixel (469,280) -> rgb F80 one cycle later. Pixel (468,280) -> 000. Pixel (519,280) (gap) -> 000. Pixel (518,329) -> F80.
4. Write (0,0)=blocked during an active line; probe pixel (229,40) on the next frame -> 888. Write (9,0) -> no change to any cell.
5. Mode WIN, cursor (1,0): pixel (289,40) -> AAF. Background pixel (200,300) -> 0F0. Blanking pixel (10,10) -> 000, bright=0.
6. Assert reset at hCount=500, vCount=200 with cell (0,0) blocked -> outputs take reset values without waiting for a clock edge. After release, (0,0) renders FFF and (4,4) renders F80.
